dspmux_fade: RTL

- Parametrised successor to the two-input DSP bypass switch.
- Selects one of NIN sample streams onto a single output.
- A channel change never steps the output abruptly. The old channel is ramped to zero in 2^LGRAMP gain steps, then the new channel is ramped up from zero.
- Sits between parallel filter chains and the DAC/output path. Stream timing stays with i_ce/o_ce at one-clock latency.

---
 rtl/dspmux_fade_if.sv | 26 ++
 rtl/dspmux_fade.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dspmux_fade_if.sv
// Sample-stream bundle for dspmux_fade: strobe, packed channels, select in;
// strobe, gained sample, busy flag and current channel out.
interface dspmux_fade_if #(
  parameter int DW  = 16,
  parameter int NIN = 4
);
  localparam int SW = $clog2(NIN);

  logic                 i_ce;
  logic [NIN*DW-1:0]    i_sample;
  logic [SW-1:0]        i_sel;
  logic                 o_ce;
  logic signed [DW-1:0] o_sample;
  logic                 o_busy;
  logic [SW-1:0]        o_cur;

  modport master (
    output i_ce, i_sample, i_sel,
    input  o_ce, o_sample, o_busy, o_cur
  );

  modport slave (
    input  i_ce, i_sample, i_sel,
    output o_ce, o_sample, o_busy, o_cur
  );
endinterface

// File: rtl/dspmux_fade.sv
// N-way sample selector that fades the old channel to zero and the new one up.
// Ports: i_clk, i_reset (sync, high), bus (slave): i_ce/i_sample/i_sel -> o_ce/o_sample/o_busy/o_cur.
module dspmux_fade #(
  parameter int DW     = 16,
  parameter int NIN    = 4,
  parameter int LGRAMP = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  dspmux_fade_if.slave  bus
);
  localparam int SW = $clog2(NIN);
  localparam int GW = LGRAMP + 1;
  localparam int PW = DW + LGRAMP + 1;

  localparam logic [GW-1:0] FULL = GW'(1 << LGRAMP);
  localparam logic [GW-1:0] ONE  = GW'(1);
  localparam logic [GW-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    PASS,
    FADEOUT,
    FADEIN
  } state_t;

  state_t           state, state_n;
  logic [GW-1:0]    g, g_n;
  logic [SW-1:0]    cur, cur_n;
  logic [SW-1:0]    pend, pend_n;

  logic signed [DW-1:0] ch [NIN];
  logic signed [DW-1:0] x;
  logic signed [PW-1:0] x_ext, g_ext, prod;
  logic signed [DW-1:0] scaled;
  logic                 sel_ok;
  logic signed [DW-1:0] sample_n;
  logic                 busy_n;

  for (genvar k = 0; k < NIN; k++) begin : g_ch
    assign ch[k] = bus.i_sample[k*DW +: DW];
  end

  assign sel_ok = (int'(bus.i_sel) < NIN);
  assign x      = ch[cur];

  // g never exceeds FULL, so the floor-shifted product always fits DW bits
  assign x_ext  = {{(PW-DW){x[DW-1]}}, x};
  assign g_ext  = {{(PW-GW){1'b0}}, g};
  assign prod   = x_ext * g_ext;
  assign scaled = DW'(prod >>> LGRAMP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= PASS;
      g     <= FULL;
      cur   <= '0;
      pend  <= '0;
    end else if (bus.i_ce) begin
      state <= state_n;
      g     <= g_n;
      cur   <= cur_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    cur_n   = cur;
    pend_n  = pend;
    unique case (state)
      PASS: begin
        if (sel_ok && bus.i_sel != cur) begin
          pend_n  = bus.i_sel;
          g_n     = FULL - ONE;
          state_n = FADEOUT;
        end
      end
      FADEOUT: begin
        if (sel_ok) pend_n = bus.i_sel;
        if (g != ZERO) begin
          g_n = g - ONE;
        end else begin
          // swap uses the request held before this ce
          cur_n   = pend;
          g_n     = ONE;
          state_n = FADEIN;
        end
      end
      FADEIN: begin
        g_n = g + ONE;
        if (g + ONE == FULL) state_n = PASS;
      end
      default: begin
        state_n = PASS;
        g_n     = FULL;
      end
    endcase
  end

  always_comb begin
    sample_n = scaled;
    busy_n   = (state != PASS);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_ce     <= 1'b0;
      bus.o_sample <= '0;
      bus.o_busy   <= 1'b0;
    end else begin
      bus.o_ce <= bus.i_ce;
      if (bus.i_ce) begin
        bus.o_sample <= sample_n;
        bus.o_busy   <= busy_n;
      end
    end
  end

  assign bus.o_cur = cur;
endmodule
